pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded by reset.
REQ-002 Parameter ADDR_W, default 32, PC width; legal range 30..32; upper bits beyond ADDR_W are dropped.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 stall  in  1  hazard-unit freeze of F and D; PC holds and the D decision is ignored.
REQ-006 im_ready  in  1  instruction memory accepts F_pc this cycle.
REQ-007 D_valid  in  1  D holds a real, non-nullified instruction.
REQ-008 NPCOp  in  4  D branch/jump class: 0 seq, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr, 11 bgezal, 12 bgezall; 13-15 behave as 0.
REQ-009 D_pc  in  ADDR_W  PC of the D instruction.
REQ-010 imm26  in  26  instruction index field; [15:0] is the branch offset.
REQ-011 RD1 / RD2  in  32 each  forwarded rs / rt values.
REQ-012 F_pc  out  ADDR_W  registered fetch address.
REQ-013 redirect  out  1  D decision taken and accepted this cycle.
REQ-014 D_link  out  1  taken link op (8, 10, taken 11, taken 12); link address is D_pc+8.
REQ-015 pending  out  1  a redirect is latched and not yet applied.
REQ-016 F_nullify  out  1  the instruction fetched at F_pc is killed on entry to D.

Function
REQ-017 Decision accepted = D_valid && !stall; otherwise redirect=0, D_link=0.
REQ-018 Conditions: beq RD1==RD2; bne RD1!=RD2; blez/bgtz/bltz/bgez/bgezal/bgezall use signed RD1 against 0; ops 7-10 are always taken.
REQ-019 Branch target = D_pc+4+(sign-extended imm26[15:0]<<2), modulo 2^ADDR_W; j/jal target = {D_pc[ADDR_W-1:28], imm26, 2'b00}; jr/jalr target = RD1[ADDR_W-1:0].
REQ-020 F advances when im_ready && !stall; otherwise F_pc holds.
REQ-021 On advance, priority: pending -> F_pc<=pending target, clear pending; else redirect -> F_pc<=target; else F_pc<=F_pc+4.
REQ-022 A redirect in a non-advance cycle latches its target and sets pending; a second redirect while pending overwrites the target (latest wins).
REQ-023 A redirect coinciding with an advance while pending=1: the pending target is applied and the new target is latched; pending stays 1.
REQ-024 Wrap-around: F_pc+4 and branch targets wrap modulo 2^ADDR_W without error.
REQ-025 No combinational path from im_ready to redirect or D_link.

Reset
REQ-026 While reset=1 on a clock edge: F_pc<=RESET_PC, pending<=0, pending target<=0, F_nullify<=0; reset overrides stall, im_ready and any redirect in that cycle.
REQ-027 Reset mid-pending discards the latched target; the first fetch after reset is RESET_PC.

Configuration
REQ-028 Macro PC_GEN_BRANCH_LIKELY_EN defined: accepted, not-taken bgezall sets F_nullify on the next edge; F_nullify clears on the next advance unless set again in that cycle.
REQ-029 Macro undefined: bgezall behaves exactly as bgezal and F_nullify is constant 0.

Verification
REQ-030 Reset, then 3 cycles with im_ready=1 and NPCOp=0 -> F_pc sequence 0x3000, 0x3004, 0x3008, 0x300C.
REQ-031 D_pc=0x3000, beq, RD1=RD2=5, imm16=0xFFFF, im_ready=1 -> redirect=1, next F_pc=0x3000; with RD2=6 -> F_pc+4.
REQ-032 jal imm26=0x0000C10 with im_ready=0 for 2 cycles -> pending=1 and F_pc held; on im_ready=1 -> F_pc=0x3040 and pending=0.
REQ-033 jr with RD1=0x4000 and stall=1 -> redirect=0, F_pc held; stall drops -> F_pc=0x4000.
REQ-034 With macro: bgezall, RD1=-1 -> D_link=0, F_nullify=1 for exactly one advance; RD1=0 -> redirect=1, D_link=1, F_nullify=0; without macro, F_nullify is always 0.
REQ-035 Reset asserted while pending=1 -> pending=0 and F_pc=0x3000 after the edge; the latched target is never fetched.

Source files
------------

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch-address generator for the F stage.
//
// Holds the registered fetch address F_pc and resolves the branch/jump
// decision of the instruction currently in D. A taken decision that cannot
// be applied because instruction memory is not accepting this cycle is
// parked in a pending target register and applied on the next advance.
//
// Parameters
//   RESET_PC  : fetch address loaded by reset (default 32'h0000_3000)
//   ADDR_W    : PC width, 30..32; upper bits beyond ADDR_W are dropped
//
// Ports
//   clk       in   single clock, all state updates on the rising edge
//   reset     in   synchronous, active-high
//   stall     in   hazard freeze of F and D; PC holds, D decision ignored
//   im_ready  in   instruction memory accepts F_pc this cycle
//   D_valid   in   D holds a real, non-nullified instruction
//   NPCOp     in   D branch/jump class (see npc_op_e; 13-15 act as seq)
//   D_pc      in   PC of the D instruction
//   imm26     in   instruction index field; [15:0] is the branch offset
//   RD1, RD2  in   forwarded rs / rt values
//   F_pc      out  registered fetch address
//   redirect  out  D decision taken and accepted this cycle
//   D_link    out  taken link op; link address is D_pc+8
//   pending   out  a redirect is latched and not yet applied
//   F_nullify out  instruction fetched at F_pc is killed on entry to D
//
// Configuration
//   PC_GEN_BRANCH_LIKELY_EN : when defined, an accepted not-taken bgezall
//   nullifies the following fetch. When undefined, bgezall behaves as
//   bgezal and F_nullify is tied low.
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              im_ready,
    input  logic              D_valid,
    input  logic [3:0]        NPCOp,
    input  logic [ADDR_W-1:0] D_pc,
    input  logic [25:0]       imm26,
    input  logic [31:0]       RD1,
    input  logic [31:0]       RD2,
    output logic [ADDR_W-1:0] F_pc,
    output logic              redirect,
    output logic              D_link,
    output logic              pending,
    output logic              F_nullify
);

    typedef enum logic [3:0] {
        OP_SEQ     = 4'd0,
        OP_BEQ     = 4'd1,
        OP_BNE     = 4'd2,
        OP_BLEZ    = 4'd3,
        OP_BGTZ    = 4'd4,
        OP_BLTZ    = 4'd5,
        OP_BGEZ    = 4'd6,
        OP_J       = 4'd7,
        OP_JAL     = 4'd8,
        OP_JR      = 4'd9,
        OP_JALR    = 4'd10,
        OP_BGEZAL  = 4'd11,
        OP_BGEZALL = 4'd12
    } npc_op_e;

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    npc_op_e           op;
    logic              accepted;
    logic              advance;
    logic              taken;
    logic              is_link;
    logic              rd1_neg;
    logic              rd1_zero;
    logic [31:0]       br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pend_tgt;

    // Codes 13-15 are outside the enum and fall to the default (sequential).
    assign op       = npc_op_e'(NPCOp);
    assign accepted = D_valid && !stall;
    assign advance  = im_ready && !stall;

    assign rd1_neg  = RD1[31];
    assign rd1_zero = (RD1 == 32'd0);

    // Branch offset is formed at 32 bits, then truncated so that narrow
    // PCs wrap modulo 2^ADDR_W exactly like the full-width sum.
    assign br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign br_tgt = D_pc + PC_STEP + br_off[ADDR_W-1:0];
    assign j_tgt  = {D_pc[ADDR_W-1:28], imm26, 2'b00};

    // Decision logic depends only on D-side inputs and stall, never on
    // im_ready, so there is no path from memory handshake to redirect.
    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        target  = br_tgt;
        case (op)
            OP_BEQ:  taken = (RD1 == RD2);
            OP_BNE:  taken = (RD1 != RD2);
            OP_BLEZ: taken = rd1_neg || rd1_zero;
            OP_BGTZ: taken = !rd1_neg && !rd1_zero;
            OP_BLTZ: taken = rd1_neg;
            OP_BGEZ: taken = !rd1_neg;
            OP_J: begin
                taken  = 1'b1;
                target = j_tgt;
            end
            OP_JAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = j_tgt;
            end
            OP_JR: begin
                taken  = 1'b1;
                target = RD1[ADDR_W-1:0];
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = RD1[ADDR_W-1:0];
            end
            OP_BGEZAL, OP_BGEZALL: begin
                taken   = !rd1_neg;
                is_link = !rd1_neg;
            end
            default: begin
                taken   = 1'b0;
                is_link = 1'b0;
            end
        endcase
    end

    assign redirect = accepted && taken;
    assign D_link   = accepted && is_link;

    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc     <= RESET_PC_W;
            pending  <= 1'b0;
            pend_tgt <= '0;
        end else if (advance) begin
            if (pending) begin
                // Older parked target goes first; a coincident redirect is
                // parked behind it, so pending stays set in that case.
                F_pc <= pend_tgt;
                if (redirect) begin
                    pend_tgt <= target;
                end else begin
                    pending <= 1'b0;
                end
            end else if (redirect) begin
                F_pc <= target;
            end else begin
                F_pc <= F_pc + PC_STEP;
            end
        end else if (redirect) begin
            // Latest redirect wins while waiting for memory.
            pend_tgt <= target;
            pending  <= 1'b1;
        end
    end

`ifdef PC_GEN_BRANCH_LIKELY_EN
    // Not-taken branch-likely kills the fetch behind it; the flag survives
    // until the next advance consumes that fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_nullify <= 1'b0;
        end else if (accepted && (op == OP_BGEZALL) && !taken) begin
            F_nullify <= 1'b1;
        end else if (advance) begin
            F_nullify <= 1'b0;
        end
    end
`else
    assign F_nullify = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        im_ready;
    logic        D_valid;
    logic [3:0]  NPCOp;
    logic [31:0] D_pc;
    logic [25:0] imm26;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] F_pc;
    logic        redirect;
    logic        D_link;
    logic        pending;
    logic        F_nullify;

    pc_gen #(
        .RESET_PC(32'h0000_3000),
        .ADDR_W  (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .im_ready (im_ready),
        .D_valid  (D_valid),
        .NPCOp    (NPCOp),
        .D_pc     (D_pc),
        .imm26    (imm26),
        .RD1      (RD1),
        .RD2      (RD2),
        .F_pc     (F_pc),
        .redirect (redirect),
        .D_link   (D_link),
        .pending  (pending),
        .F_nullify(F_nullify)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_comb;
        bit          red;
        bit          link;
        logic [31:0] pc;
        bit          pend;
        bit          nul;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: what the fetch unit should hold after each edge.
    logic [31:0] m_pc   = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_tgt  = 32'h0;
    bit          m_nul  = 1'b0;

    function automatic bit m_taken(int op, logic [31:0] r1, logic [31:0] r2);
        int s1;
        s1 = $signed(r1);
        case (op)
            1:         return r1 == r2;
            2:         return r1 != r2;
            3:         return s1 <= 0;
            4:         return s1 > 0;
            5:         return s1 < 0;
            6, 11, 12: return s1 >= 0;
            7, 8, 9, 10: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(int op, logic [31:0] dpc,
                                             logic [25:0] imm, logic [31:0] r1);
        int          off;
        logic [15:0] i16;
        if (op == 7 || op == 8)
            return (dpc & 32'hF000_0000) | (32'(imm) * 32'd4);
        if (op == 9 || op == 10)
            return r1;
        i16 = imm[15:0];
        off = int'($signed(i16)) * 4;
        return dpc + 32'd4 + 32'(off);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge, checked 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_comb) begin
                    chk("redirect", 32'(redirect), 32'(e.red));
                    chk("D_link",   32'(D_link),   32'(e.link));
                end
                chk("F_pc",      F_pc,              e.pc);
                chk("pending",   32'(pending),      32'(e.pend));
                chk("F_nullify", 32'(F_nullify),    32'(e.nul));
            end
        end
    end

    // Drive one cycle's inputs, predict the response, hand it to the monitor.
    task automatic step(input bit rst, input bit stl, input bit imr, input bit dv,
                        input logic [3:0] op, input logic [31:0] dpc,
                        input logic [25:0] imm, input logic [31:0] r1,
                        input logic [31:0] r2);
        exp_t        e;
        bit          acc, adv, tk, red;
        logic [31:0] t;
        int          o;
        reset = rst; stall = stl; im_ready = imr; D_valid = dv;
        NPCOp = op; D_pc = dpc; imm26 = imm; RD1 = r1; RD2 = r2;

        o   = int'(op);
        acc = dv && !stl;
        adv = imr && !stl;
        tk  = m_taken(o, r1, r2);
        t   = m_target(o, dpc, imm, r1);
        red = acc && tk;
        e.chk_comb = !rst;
        e.red      = red;
        e.link     = acc && (o == 8 || o == 10 || ((o == 11 || o == 12) && tk));

        if (rst) begin
            m_pc = 32'h0000_3000; m_pend = 0; m_tgt = 0; m_nul = 0;
        end else begin
`ifdef PC_GEN_BRANCH_LIKELY_EN
            if (acc && o == 12 && !tk) m_nul = 1;
            else if (adv)              m_nul = 0;
`endif
            if (adv) begin
                if (m_pend) begin
                    m_pc = m_tgt;
                    if (red) m_tgt = t;
                    else     m_pend = 0;
                end else if (red) begin
                    m_pc = t;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (red) begin
                m_pend = 1; m_tgt = t;
            end
        end
        e.pc = m_pc; e.pend = m_pend; e.nul = m_nul;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r1, r2, dpc;
        reset = 1; stall = 0; im_ready = 0; D_valid = 0; NPCOp = 0;
        D_pc = 0; imm26 = 0; RD1 = 0; RD2 = 0;
        @(posedge clk);
        #2;

        // Reset then plain sequential fetch: 3000, 3004, 3008, 300C.
        step(1, 0, 1, 0, 4'd0, 32'h0, 26'h0, 32'h0, 32'h0);
        repeat (3) step(0, 0, 1, 1, 4'd0, 32'h3000, 26'h0, 32'h0, 32'h0);

        // beq backwards by one word to itself, then not-taken.
        step(0, 0, 1, 1, 4'd1, 32'h3000, 26'h0FFFF, 32'd5, 32'd5);
        step(0, 0, 1, 1, 4'd1, 32'h3000, 26'h0FFFF, 32'd5, 32'd6);

        // jal with memory busy for two cycles, then applied.
        step(0, 0, 0, 1, 4'd8, 32'h3000, 26'h0000C10, 32'h0, 32'h0);
        step(0, 0, 0, 1, 4'd8, 32'h3000, 26'h0000C10, 32'h0, 32'h0);
        step(0, 0, 1, 0, 4'd8, 32'h3000, 26'h0000C10, 32'h0, 32'h0);

        // jr under stall is ignored, then taken once stall drops.
        step(0, 1, 1, 1, 4'd9, 32'h3040, 26'h0, 32'h4000, 32'h0);
        step(0, 0, 1, 1, 4'd9, 32'h3040, 26'h0, 32'h4000, 32'h0);

        // bgezall not-taken, then a plain advance, then taken with link.
        step(0, 0, 1, 1, 4'd12, 32'h4000, 26'h00010, 32'hFFFF_FFFF, 32'h0);
        step(0, 0, 1, 1, 4'd0,  32'h4004, 26'h0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 4'd12, 32'h4008, 26'h00010, 32'h0, 32'h0);

        // Pending target plus a coincident redirect on the advance.
        step(0, 0, 0, 1, 4'd9, 32'h4000, 26'h0, 32'h5000, 32'h0);
        step(0, 0, 1, 1, 4'd9, 32'h4000, 26'h0, 32'h6000, 32'h0);
        step(0, 0, 1, 1, 4'd0, 32'h4000, 26'h0, 32'h0, 32'h0);

        // Reset while pending discards the parked target.
        step(0, 0, 0, 1, 4'd7, 32'h6000, 26'h0000400, 32'h0, 32'h0);
        step(1, 1, 1, 1, 4'd7, 32'h6000, 26'h0000400, 32'h0, 32'h0);
        step(0, 0, 1, 0, 4'd0, 32'h0, 26'h0, 32'h0, 32'h0);

        // Wrap-around of F_pc+4 and of a branch target.
        step(0, 0, 1, 1, 4'd10, 32'h3000, 26'h0, 32'hFFFF_FFFC, 32'h0);
        step(0, 0, 1, 0, 4'd0,  32'h0, 26'h0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 4'd1,  32'hFFFF_FFF8, 26'h00004, 32'd7, 32'd7);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       r1 = 32'h0;
                1:       r1 = 32'hFFFF_FFFF;
                2:       r1 = $urandom_range(1, 100);
                default: r1 = $urandom;
            endcase
            r2  = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            dpc = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) != 0,
                 4'($urandom_range(0, 15)),
                 dpc, 26'($urandom), r1, r2);
        end

        // Every predicted cycle must have been consumed by the monitor.
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
